// File: rtl/fixed_point_accumulator.sv
// Streaming saturating accumulator for the ODE fixed-point datapath.
// Terms are summed one per beat through a parallel-prefix carry-lookahead
// adder; a beat flagged last closes the sum and offers it downstream.

// Parallel-prefix (Kogge-Stone) carry-lookahead adder with sign flags.
module carry_lookahead_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow_flag,
    output logic         negative
);

    logic [N-1:0] prop;
    logic [N-1:0] grp_g;
    logic [N-1:0] grp_p;
    logic [N:0]   carry;

    // Prefix tree: grp_g[i] becomes the carry out of bit i, with cin folded into bit 0.
    always_comb begin
        // NOTE: every variable gets a value before any conditional or loop
        // update, so no path through the block leaves a latch behind.
        prop  = a ^ b;
        grp_g = a & b;
        grp_p = prop;
        grp_g[0] = grp_g[0] | (prop[0] & cin);
        // Walking i downwards lets each level read the previous level's
        // value at i-d before it is overwritten in place.
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = N - 1; i >= d; i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                grp_p[i] = grp_p[i] & grp_p[i-d];
            end
        end
        carry         = {grp_g, cin};
        sum           = prop ^ carry[N-1:0];
        carry_out     = carry[N];
        overflow_flag = carry[N] ^ carry[N-1];
        // Sign of the exact (unbounded) result: on overflow the MSB is flipped.
        negative      = sum[N-1] ^ overflow_flag;
    end

endmodule

module fixed_point_accumulator #(
    parameter int N     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       acc;
    logic [CNT_W-1:0]   count;
    logic               sat;

    logic [N-1:0]       add_b;
    logic [N-1:0]       add_sum;
    logic               add_cout;
    logic               add_ovf;
    logic               add_neg;
    logic [N-1:0]       acc_nxt;
    logic               accept;
    logic               drain;

    // Subtraction is acc + ~in_data + 1 through the same adder.
    assign add_b = in_sub ? ~in_data : in_data;

    carry_lookahead_adder #(.N(N)) u_adder (
        .a             (acc),
        .b             (add_b),
        .cin           (in_sub),
        .sum           (add_sum),
        .carry_out     (add_cout),
        .overflow_flag (add_ovf),
        .negative      (add_neg)
    );

    // Clamp to the extreme of the true sign when the sum leaves the range.
    assign acc_nxt = !add_ovf ? add_sum
                   : add_neg  ? {1'b1, {(N-1){1'b0}}}
                   :            {1'b0, {(N-1){1'b1}}};

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= ST_ACC;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; both depend on state only, so
    // out_ready never reaches in_ready combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (accept && in_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    // Datapath: absorb accepted terms, clear once the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            count <= (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
            sat   <= sat | add_ovf;
        end else if (drain) begin
            acc   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end
    end

    // Accumulator registers are frozen in DONE, so they serve directly as the result.
    assign out_data  = acc;
    assign out_sat   = sat;
    assign out_count = count;

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Self-checking bench for fixed_point_accumulator: directed scenarios plus
// randomized streams, compared against an integer clamp-and-sum model.
module tb_fixed_point_accumulator;

    localparam int N     = 16;
    localparam int CNT_W = 8;
    localparam int MAX_V = 32767;
    localparam int MIN_V = -32768;
    localparam int CNT_MAX = 255;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_sub;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state.
    bit m_done;
    int m_sum;
    bit m_sat;
    int m_cnt;

    fixed_point_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_done = 1'b0;
        m_sum  = 0;
        m_sat  = 1'b0;
        m_cnt  = 0;
    endtask

    // One clock cycle: drive at negedge, check against the model, then
    // advance the model to what the coming rising edge should do.
    task automatic cycle(input logic v, input logic [N-1:0] d, input logic s,
                         input logic l, input logic ordy);
        int term;
        int raw;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_sub    = s;
        in_last   = l;
        out_ready = ordy;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_done));
        check("out_valid", 32'(out_valid), 32'(m_done));
        if (m_done) begin
            check("out_data", 32'(out_data), 32'(m_sum[N-1:0]));
            check("out_sat", 32'(out_sat), 32'(m_sat));
            check("out_count", 32'(out_count), 32'(m_cnt));
        end
        if (!m_done) begin
            if (v) begin
                term = int'($signed(d));
                raw  = s ? m_sum - term : m_sum + term;
                if (raw > MAX_V)      begin m_sum = MAX_V; m_sat = 1'b1; end
                else if (raw < MIN_V) begin m_sum = MIN_V; m_sat = 1'b1; end
                else                        m_sum = raw;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (l) m_done = 1'b1;
            end
        end else if (ordy) begin
            model_reset();
        end
    endtask

    task automatic beat(input logic [N-1:0] d, input logic s, input logic l);
        cycle(1'b1, d, s, l, 1'b1);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, 1'b0, 1'b0, ordy);
    endtask

    // Hand-derived result check; call right after an idle cycle that saw DONE.
    task automatic expect_result(input string tag, input logic [N-1:0] d,
                                 input logic s, input logic [CNT_W-1:0] c);
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_sat"}, 32'(out_sat), 32'(s));
        check({tag, "_count"}, 32'(out_count), 32'(c));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_sat", 32'(out_sat), 32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N-1:0] rand_term();
        unique case ($urandom_range(0, 3))
            0:       return N'($urandom);
            1:       return N'($urandom_range(16'h6000, 16'h7FFF));
            2:       return N'($urandom_range(16'h8000, 16'hA000));
            default: return N'($urandom_range(0, 16'h00FF));
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset();

        // 1: plain sum, result one cycle after the last beat
        beat(16'h0100, 1'b0, 1'b0);
        beat(16'h0200, 1'b0, 1'b0);
        beat(16'h0080, 1'b0, 1'b1);
        idle(1'b0);
        expect_result("t1", 16'h0380, 1'b0, 8'd3);
        idle(1'b1);

        // 2: positive saturation, then continue from the clamp
        beat(16'h7000, 1'b0, 1'b0);
        beat(16'h2000, 1'b0, 1'b0);
        beat(16'h1000, 1'b1, 1'b1);
        idle(1'b0);
        expect_result("t2", 16'h6FFF, 1'b1, 8'd3);
        idle(1'b1);

        // 3: subtracting the most negative value, then negative saturation
        beat(16'h8000, 1'b1, 1'b1);
        idle(1'b0);
        expect_result("t3a", 16'h7FFF, 1'b1, 8'd1);
        idle(1'b1);
        beat(16'h8000, 1'b0, 1'b0);
        beat(16'hFFFF, 1'b0, 1'b1);
        idle(1'b0);
        expect_result("t3b", 16'h8000, 1'b1, 8'd2);
        idle(1'b1);

        // 4: backpressure while terms are offered
        beat(16'h0003, 1'b0, 1'b1);
        repeat (5) cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        expect_result("t4a", 16'h0003, 1'b0, 8'd1);
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 16'h0005, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        expect_result("t4b", 16'h0005, 1'b0, 8'd1);
        idle(1'b1);

        // 5: single beat, then reset in the middle of a stream
        beat(16'hFFF0, 1'b0, 1'b1);
        idle(1'b0);
        expect_result("t5a", 16'hFFF0, 1'b0, 8'd1);
        idle(1'b1);
        beat(16'h1234, 1'b0, 1'b0);
        beat(16'h7FFF, 1'b0, 1'b0);
        apply_reset();
        beat(16'h0001, 1'b0, 1'b1);
        idle(1'b0);
        expect_result("t5b", 16'h0001, 1'b0, 8'd1);
        idle(1'b1);

        // 6: term counter saturates instead of wrapping
        repeat (300) beat(16'h0000, 1'b0, 1'b0);
        beat(16'h0000, 1'b0, 1'b1);
        idle(1'b0);
        expect_result("t6", 16'h0000, 1'b0, 8'hFF);
        idle(1'b1);

        // Randomized streams with gaps and random backpressure
        for (int strm = 0; strm < 60; strm++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                if ($urandom_range(0, 3) == 0) idle(1'($urandom));
                beat(rand_term(), 1'($urandom), (t == len - 1));
            end
            repeat ($urandom_range(0, 4)) idle(1'($urandom));
            idle(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
